float_point_divide: RTL and testbench

- Iterative single-precision (IEEE-754 binary32 layout) signed divider, oZ = iA / iB.
- Inverse-operation companion to the pipelined float multiplier in the float arithmetic library.
- Uses a multi-cycle restoring radix-2 mantissa divider under a small FSM, with an iValid/oReady/oDone handshake.
- Denormals are treated as zero; NaN/Inf inputs are not supported (the exponent field is used as-is).

---
 rtl/float_point_divide.sv | 162 ++++++++++++++++
 tb/tb_float_point_divide.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/float_point_divide.sv
// Iterative binary32 divider oZ = iA / iB: restoring radix-2 mantissa divide under a small FSM.
// Define FPD_ROUND_NEAREST_EN for one extra quotient bit and round-to-nearest-even; default truncates.
module float_point_divide #(
`ifdef FPD_ROUND_NEAREST_EN
    parameter int QBITS = 26
`else
    parameter int QBITS = 25
`endif
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iValid,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic        oReady,
    output logic        oDone,
    output logic [31:0] oZ,
    output logic        oDivByZero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_sign;
    logic signed [9:0]   r_exp;
    logic [23:0]         r_div;
    logic [25:0]         r_rem;
    logic                r_zA;
    logic                r_zB;
    logic [4:0]          r_cnt;
    logic [QBITS-1:0]    r_q;
    logic                r_done;
    logic [31:0]         r_z;
    logic                r_dz;

    logic [9:0]          w_expIn;
    logic [25:0]         w_diff;
    logic                w_ge;
    logic [25:0]         w_remNext;
    logic [22:0]         w_frac;
    logic signed [9:0]   w_e;
    logic [22:0]         w_fracF;
    logic signed [9:0]   w_eF;
    logic [31:0]         w_z;
    logic                w_dz;
`ifdef FPD_ROUND_NEAREST_EN
    logic                w_guard;
    logic                w_roundUp;
    logic [23:0]         w_fracSum;
`endif

    assign w_expIn = {2'b00, iA[30:23]} - {2'b00, iB[30:23]} + 10'd127;

    // The remainder stays below 2*D, so a 26-bit register never drops its MSB on the shift.
    assign w_diff    = r_rem - {2'b00, r_div};
    assign w_ge      = (r_rem >= {2'b00, r_div});
    assign w_remNext = w_ge ? {w_diff[24:0], 1'b0} : {r_rem[24:0], 1'b0};

    // The top quotient bit has weight 2^0; a clear top bit means the ratio is below 1.
    always_comb begin
        w_frac = '0;
        w_e    = '0;
        if (r_q[QBITS-1]) begin
            w_frac = r_q[QBITS-2 -: 23];
            w_e    = r_exp;
        end else begin
            w_frac = r_q[QBITS-3 -: 23];
            w_e    = r_exp - 10'sd1;
        end
    end

    always_comb begin
`ifdef FPD_ROUND_NEAREST_EN
        w_guard   = r_q[QBITS-1] ? r_q[1] : r_q[0];
        w_roundUp = w_guard & ((r_rem != '0) | w_frac[0]);
        w_fracSum = {1'b0, w_frac} + {23'b0, w_roundUp};
        w_fracF   = w_fracSum[22:0];
        w_eF      = w_fracSum[23] ? (w_e + 10'sd1) : w_e;
`else
        w_fracF   = w_frac;
        w_eF      = w_e;
`endif
    end

    // Specials take priority over the range checks and are never rounded.
    always_comb begin
        w_z  = '0;
        w_dz = 1'b0;
        if (r_zB) begin
            w_z  = {r_sign, 8'hFF, 23'b0};
            w_dz = 1'b1;
        end else if (r_zA) begin
            w_z = {r_sign, 31'b0};
        end else if (w_eF >= 10'sd255) begin
            w_z = {r_sign, 8'hFF, 23'b0};
        end else if (w_eF <= 10'sd0) begin
            w_z = {r_sign, 31'b0};
        end else begin
            w_z = {r_sign, w_eF[7:0], w_fracF};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_zA    <= 1'b0;
            r_zB    <= 1'b0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_done  <= 1'b0;
            r_z     <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (iValid) begin
                        r_sign  <= iA[31] ^ iB[31];
                        r_exp   <= w_expIn;
                        r_div   <= {1'b1, iB[22:0]};
                        r_rem   <= {2'b00, 1'b1, iA[22:0]};
                        r_zA    <= (iA[30:23] == 8'd0);
                        r_zB    <= (iB[30:23] == 8'd0);
                        r_cnt   <= 5'(QBITS - 1);
                        r_q     <= '0;
                        r_state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_rem <= w_remNext;
                    if (r_cnt == 5'd0) begin
                        r_state <= NORM;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                NORM: begin
                    r_z     <= w_z;
                    r_dz    <= w_dz;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oReady     = (r_state == IDLE);
    assign oDone      = r_done;
    assign oZ         = r_z;
    assign oDivByZero = r_dz;

endmodule

// File: tb/tb_float_point_divide.sv
// Scoreboard bench for float_point_divide: directed vectors push expectations, a forked monitor checks each oDone.
module tb_float_point_divide;

`ifdef FPD_ROUND_NEAREST_EN
    localparam int LAT = 28;
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam int LAT = 27;
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iValid = 1'b0;
    logic [31:0] iA = '0;
    logic [31:0] iB = '0;
    logic        oReady;
    logic        oDone;
    logic [31:0] oZ;
    logic        oDivByZero;

    float_point_divide dut (
        .clk        (clk),
        .resetn     (resetn),
        .iValid     (iValid),
        .iA         (iA),
        .iB         (iB),
        .oReady     (oReady),
        .oDone      (oDone),
        .oZ         (oZ),
        .oDivByZero (oDivByZero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       nm;
        logic [31:0] z;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t sbQ[$];
    int total = 0;
    int bad = 0;
    int doneSeen = 0;
    int doneExpected = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    // Every oDone must match the oldest outstanding expectation, including its latency.
    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && oDone) begin
                doneSeen++;
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_done: got oZ=0x%08h, want no oDone", oZ);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput({e.nm, "_oZ"}, oZ, e.z);
                    checkOutput({e.nm, "_div0"}, {31'b0, oDivByZero}, {31'b0, e.dz});
                    checkOutput({e.nm, "_latency"}, 32'(cyc - e.acc), 32'(LAT));
                end
            end
        end
    endtask

    // Called at a negedge; issues one operation as soon as the divider is ready.
    task automatic applyStimulus(input string nm, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expZ, input logic expDz);
        int n = 0;
        exp_t e;
        while (!oReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!oReady) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_ready_timeout: got oReady=0, want 1", nm);
        end else begin
            iA = a;
            iB = b;
            iValid = 1'b1;
            e.nm = nm;
            e.z = expZ;
            e.dz = expDz;
            e.acc = cyc;
            sbQ.push_back(e);
            doneExpected++;
            @(negedge clk);
            iValid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d pending, want 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    initial begin
        int n;
        fork
            monitorLoop();
        join_none

        #2;
        checkOutput("rst_ready", {31'b0, oReady}, 32'd1);
        checkOutput("rst_done", {31'b0, oDone}, 32'd0);
        checkOutput("rst_oZ", oZ, 32'h0);
        checkOutput("rst_div0", {31'b0, oDivByZero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        applyStimulus("one_div_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        applyStimulus("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        applyStimulus("neg_one_div_two", 32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0);
        applyStimulus("one_div_three", 32'h3F800000, 32'h40400000, THIRD, 1'b0);
        applyStimulus("five_div_zero", 32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1);
        applyStimulus("zero_div_seven", 32'h00000000, 32'h40E00000, 32'h00000000, 1'b0);
        applyStimulus("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0);
        applyStimulus("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0);
        waitDrain();

        // A request while busy must be dropped, not queued.
        applyStimulus("busy_base", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("busy_ready", {31'b0, oReady}, 32'd0);
        iA = 32'h3F800000;
        iB = 32'h3F800000;
        iValid = 1'b1;
        @(negedge clk);
        iValid = 1'b0;
        waitDrain();

        // A request in the oDone cycle is accepted immediately.
        applyStimulus("b2b_first", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        n = 0;
        while (!oDone && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_done_seen", {31'b0, oDone}, 32'd1);
        checkOutput("b2b_ready", {31'b0, oReady}, 32'd1);
        applyStimulus("b2b_second", 32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0);
        waitDrain();

        // Reset mid-divide aborts the operation without an oDone.
        applyStimulus("aborted", 32'h3F800000, 32'h40400000, THIRD, 1'b0);
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        sbQ.delete();
        doneExpected--;
        #1;
        checkOutput("abort_ready", {31'b0, oReady}, 32'd1);
        checkOutput("abort_done", {31'b0, oDone}, 32'd0);
        checkOutput("abort_oZ", oZ, 32'h0);
        checkOutput("abort_div0", {31'b0, oDivByZero}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkOutput("post_rst_ready", {31'b0, oReady}, 32'd1);
        repeat (35) @(negedge clk);
        applyStimulus("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        waitDrain();

        repeat (3) @(negedge clk);
        checkOutput("done_count", 32'(doneSeen), 32'(doneExpected));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
